// File: rtl/uart_cmd_ctrl.sv
// Host-side command engine of the SRAM tester: turns UART byte frames into
// single-byte SRAM read/write requests and returns one response byte per command.
module uart_cmd_ctrl #(
  parameter int ADDR_W    = 19,
  parameter int TO_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        r_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        w_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int              TO_W    = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_CYCLES);
  localparam logic [7:0]      OP_WR   = 8'h57;
  localparam logic [7:0]      OP_RD   = 8'h52;
  localparam logic [7:0]      RSP_OK  = 8'h4B;
  localparam logic [7:0]      RSP_BAD = 8'h3F;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, SEND} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rsp_q, rsp_d;
  logic              req_q, req_d;
  logic              txs_q, txs_d;
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      rsp_q   <= 8'h00;
      req_q   <= 1'b0;
      txs_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      req_q   <= req_d;
      txs_q   <= txs_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rsp_d   = rsp_q;
    req_d   = req_q;
    txs_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    to_d    = '0;
    case (state_q)
      IDLE: begin
        if (rx_done_tick) begin
          if (r_data == OP_WR || r_data == OP_RD) begin
            we_d    = (r_data == OP_WR);
            cnt_d   = 2'd0;
            state_d = ADDR;
          end else begin
            rsp_d   = RSP_BAD;
            err_d   = 1'b1;
            state_d = SEND;
          end
        end
      end
      ADDR: begin
        // The 24-bit address shifts in MSB first; bits above ADDR_W fall off the top.
        if (rx_done_tick) begin
          addr_d = ADDR_W'({addr_q, r_data});
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd2) state_d = we_q ? DATA : MEM;
        end else if (to_q == TO_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_done_tick) begin
          wdata_d = r_data;
          state_d = MEM;
        end else if (to_q == TO_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      MEM: begin
        // An ack is only honoured once the request is actually on the bus.
        if (rx_done_tick) err_d = 1'b1;
        if (!req_q) begin
          req_d = 1'b1;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          rsp_d   = we_q ? RSP_OK : mem_rdata;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rx_done_tick) err_d = 1'b1;
        if (tx_ready) begin
          txs_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_start  = txs_q;
  assign w_data    = rsp_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: frames push expected memory requests and
// response bytes; a memory model and a transmit monitor pop and compare them.
module tb_uart_cmd_ctrl;
  localparam int ADDR_W  = 19;
  localparam int TO_CYC  = 100;
  localparam int ACK_DLY = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_done_tick;
  logic [7:0]        r_data;
  logic              tx_ready;
  logic              tx_start;
  logic [7:0]        w_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;
  logic              mem_ack   = 1'b0;
  logic              err;

  uart_cmd_ctrl #(.ADDR_W(ADDR_W), .TO_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .r_data(r_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .w_data(w_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
  } mreq_t;

  mreq_t      exp_mem[$];
  logic [7:0] exp_tx[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks each request after ACK_DLY cycles
  logic  ack_en  = 1'b1;
  int    ack_seq = 0;
  int    ack_cyc = 0;
  mreq_t m_e;
  always begin
    @(negedge clk);
    if (mem_req && ack_en) begin
      chk("mem_queue", 32'(exp_mem.size() != 0), 32'd1);
      if (exp_mem.size() != 0) begin
        m_e = exp_mem.pop_front();
        chk("mem_we", 32'(mem_we), 32'(m_e.we));
        chk("mem_addr", 32'(mem_addr), 32'(m_e.addr));
        if (m_e.we) chk("mem_wdata", 32'(mem_wdata), 32'(m_e.wdata));
        repeat (ACK_DLY - 1) @(negedge clk);
        chk("mem_hold_req", 32'(mem_req), 32'd1);
        chk("mem_hold_addr", 32'(mem_addr), 32'(m_e.addr));
        mem_rdata = m_e.rdata;
        mem_ack   = 1'b1;
        ack_cyc   = cyc;
        ack_seq++;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("req_fall", 32'(mem_req), 32'd0);
      end else begin
        while (mem_req) @(negedge clk);
      end
    end
  end

  // Transmit/err/request monitor
  int         err_n = 0;
  int         tx_n = 0;
  int         req_n = 0;
  logic       req_prev = 1'b0;
  int         seen_seq = 0;
  logic       lat_en = 1'b1;
  logic [7:0] tx_e;
  always @(negedge clk) begin
    if (err) err_n++;
    if (mem_req && !req_prev) req_n++;
    req_prev = mem_req;
    if (tx_start) begin
      tx_n++;
      chk("tx_queue", 32'(exp_tx.size() != 0), 32'd1);
      if (exp_tx.size() != 0) begin
        tx_e = exp_tx.pop_front();
        chk("tx_data", 32'(w_data), 32'(tx_e));
        if (ack_seq != seen_seq) begin
          if (lat_en) chk("ack_to_tx", 32'(cyc - ack_cyc), 32'd2);
          seen_seq = ack_seq;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    r_data       = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_req_lat();
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_latency", 32'(n), 32'd1);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] d);
    exp_mem.push_back('{1'b1, a[ADDR_W-1:0], d, 8'h00});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57, 2);
    send_byte(a[23:16], 2);
    send_byte(a[15:8], 2);
    send_byte(a[7:0], 2);
    send_byte(d, 0);
    wait_req_lat();
  endtask

  task automatic do_read(input logic [23:0] a, input logic [7:0] rd);
    exp_mem.push_back('{1'b0, a[ADDR_W-1:0], 8'h00, rd});
    exp_tx.push_back(rd);
    send_byte(8'h52, 2);
    send_byte(a[23:16], 2);
    send_byte(a[15:8], 2);
    send_byte(a[7:0], 0);
    wait_req_lat();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_mem.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 32'(n < 300), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, t0, r0, n;
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    r_data       = 8'h00;
    tx_ready     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    t0 = tx_n;
    do_write(24'h001234, 8'hA5);
    wait_idle();
    chk("write_tx_count", 32'(tx_n - t0), 32'd1);

    t0 = tx_n;
    do_read(24'h07FFFF, 8'h3C);
    wait_idle();
    chk("read_tx_count", 32'(tx_n - t0), 32'd1);

    e0 = err_n; r0 = req_n; t0 = tx_n;
    exp_tx.push_back(8'h3F);
    send_byte(8'h41, 0);
    wait_idle();
    chk("badop_err", 32'(err_n - e0), 32'd1);
    chk("badop_no_req", 32'(req_n - r0), 32'd0);
    chk("badop_tx_count", 32'(tx_n - t0), 32'd1);
    do_read(24'h123456, 8'h96);
    wait_idle();

    e0 = err_n; r0 = req_n; t0 = tx_n;
    send_byte(8'h57, 2);
    send_byte(8'h00, 0);
    repeat (TO_CYC + 10) @(negedge clk);
    chk("timeout_err", 32'(err_n - e0), 32'd1);
    chk("timeout_no_req", 32'(req_n - r0), 32'd0);
    chk("timeout_no_tx", 32'(tx_n - t0), 32'd0);
    do_read(24'h000010, 8'h5A);
    wait_idle();

    tx_ready = 1'b0;
    lat_en   = 1'b0;
    t0 = tx_n;
    do_read(24'h000ABC, 8'hC3);
    n = 0;
    while (exp_mem.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    chk("bp_no_tx", 32'(tx_n - t0), 32'd0);
    chk("bp_w_data_held", 32'(w_data), 32'hC3);
    e0 = err_n;
    send_byte(8'h77, 2);
    chk("overrun_err", 32'(err_n - e0), 32'd1);
    chk("overrun_no_tx", 32'(tx_n - t0), 32'd0);
    tx_ready = 1'b1;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("bp_one_tx", 32'(tx_n - t0), 32'd1);
    chk("bp_w_data_after", 32'(w_data), 32'hC3);
    lat_en = 1'b1;

    ack_en = 1'b0;
    send_byte(8'h57, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 2);
    send_byte(8'h01, 2);
    send_byte(8'h11, 0);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_req_seen", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_tx_start", 32'(tx_start), 32'd0);
    chk("rst_mid_w_data", 32'(w_data), 32'd0);
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mid_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);

    t0 = tx_n;
    do_write(24'h054321, 8'h3E);
    wait_idle();
    chk("post_rst_tx_count", 32'(tx_n - t0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
